conv3x3_window_gen: RTL and testbench

- Streaming 3x3 sliding-window generator that feeds the 9-input fp16 adder tree and multiplier array of the conv accelerator.
- Accepts one 16-bit pixel per handshake in raster order.
- Keeps two line buffers and emits a full 3x3 neighbourhood (9 x 16 bit) per valid output position.
- The adder tree reduces 9 values to 1; this block fans 1 value out to 9. It is the producer end of that interface.

---
 rtl/conv3x3_window_gen.sv | 120 ++++++++++++
 tb/tb_conv3x3_window_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_window_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a 3x3 shift register, raster-order input.
// Optional build macro WINGEN_WIN_CNT_EN adds the win_cnt output (windows consumed in the current frame).
module conv3x3_window_gen #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [9*DATA_W-1:0]   win,
`ifdef WINGEN_WIN_CNT_EN
    output logic [$clog2((IMG_W-2)*(IMG_H-2)+1)-1:0] win_cnt,
`endif
    output logic                  frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    // state | meaning
    // IDLE  | waiting for pixel (0,0) of a frame
    // FILL  | rows 0-1, priming the line buffers, no windows
    // RUN   | rows >= 2, windows emitted for columns >= 2
    // DONE  | whole frame accepted, waiting for the last window to drain
    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    state_t            state_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [DATA_W-1:0] lb0_q [IMG_W];
    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] sr_q  [9];
    logic              win_valid_q;
    logic              frame_done_q;

    logic accept, col_last, row_last, emit;

    assign in_ready = (state_q != DONE) && (!win_valid_q || win_ready);
    assign accept   = in_valid && in_ready;
    assign col_last = (col_q == CW'(IMG_W-1));
    assign row_last = (row_q == RW'(IMG_H-1));
    assign emit     = (row_q >= RW'(2)) && (col_q >= CW'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 9; i++) sr_q[i] <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (accept) begin
                // sr_q is row-major: column 2 of each row takes the freshly arrived column
                for (int i = 0; i < 3; i++) begin
                    sr_q[i*3]   <= sr_q[i*3+1];
                    sr_q[i*3+1] <= sr_q[i*3+2];
                end
                sr_q[2]     <= lb0_q[col_q];
                sr_q[5]     <= lb1_q[col_q];
                sr_q[8]     <= in_data;
                win_valid_q <= emit;
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
                case (state_q)
                    IDLE:    state_q <= FILL;
                    FILL:    if (row_q == RW'(1) && col_last) state_q <= RUN;
                    RUN:     if (row_last && col_last) state_q <= DONE;
                    default: state_q <= state_q;
                endcase
            end else if (win_ready) begin
                win_valid_q <= 1'b0;
            end
            if (state_q == DONE && win_valid_q && win_ready) begin
                state_q      <= IDLE;
                frame_done_q <= 1'b1;
            end
        end
    end

    // Line buffers are never reset; each entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            lb0_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= in_data;
        end
    end

    for (genvar g = 0; g < 9; g++) begin : g_win
        assign win[g*DATA_W +: DATA_W] = sr_q[g];
    end

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

`ifdef WINGEN_WIN_CNT_EN
    localparam int NW = $clog2((IMG_W-2)*(IMG_H-2)+1);
    logic [NW-1:0] win_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || frame_done_q) begin
            win_cnt_q <= '0;
        end else if (win_valid_q && win_ready) begin
            win_cnt_q <= win_cnt_q + NW'(1);
        end
    end

    assign win_cnt = win_cnt_q;
`endif

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Directed bench for conv3x3_window_gen on a 4x4 frame with hand-computed windows.
// Build with WINGEN_WIN_CNT_EN defined to also cover the win_cnt output.
module tb_conv3x3_window_gen;
    localparam int DW = 16;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            win_valid;
    logic            win_ready;
    logic [9*DW-1:0] win;
    logic            frame_done;
`ifdef WINGEN_WIN_CNT_EN
    logic [2:0]      win_cnt;
`endif

    conv3x3_window_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win        (win),
`ifdef WINGEN_WIN_CNT_EN
        .win_cnt    (win_cnt),
`endif
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    logic [9*DW-1:0] win_q [$];
    int fd_cnt = 0;
    int px_idx = 0;
    bit lat_en = 0;
    bit prev_acc = 0;
    bit prev_cons = 0;
    bit prev_fd = 0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [9*DW-1:0] got, input logic [9*DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // window k of a 4x4 frame whose pixel (r,c) = base + r*4 + c
    function automatic logic [9*DW-1:0] exp_win(input int base, input int k);
        logic [9*DW-1:0] v;
        int r, c;
        r = 2 + k / 2;
        c = 2 + k % 2;
        v = '0;
        for (int i = 0; i < 9; i++)
            v[i*DW +: DW] = 16'(base + (r - 2 + i / 3) * 4 + (c - 2 + i % 3));
        return v;
    endfunction

    always @(negedge clk) begin
        if (win_valid === 1'b1 && win_ready === 1'b1) begin
            win_q.push_back(win);
            if (lat_en) begin
                chk("lat_acc", 144'(prev_acc), 144'(1));
                chk("lat_px", 144'(win[8*DW +: DW]), 144'(prev_data));
            end
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            chk("fd_after_win", 144'(prev_cons), 144'(1));
`ifdef WINGEN_WIN_CNT_EN
            chk("cnt_at_fd", 144'(win_cnt), 144'(4));
`endif
        end
`ifdef WINGEN_WIN_CNT_EN
        if (prev_fd) chk("cnt_clr", 144'(win_cnt), 144'(0));
`endif
        prev_acc  = (in_valid === 1'b1) && (in_ready === 1'b1) && (rst === 1'b0);
        prev_data = in_data;
        prev_cons = (win_valid === 1'b1) && (win_ready === 1'b1);
        prev_fd   = (frame_done === 1'b1);
    end

    task automatic send_px(input logic [DW-1:0] d, input bit gaps);
        bit done = 0;
        int budget = 0;
        while (!done) begin
            in_data  = d;
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            done = (in_valid && in_ready);
            @(posedge clk);
            #1;
            budget++;
            if (!done && budget > 200) begin
                chk("px_timeout", 144'(0), 144'(1));
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit gaps);
        for (int p = 0; p < 16; p++) begin
            px_idx = p;
            send_px(16'(base + p), gaps);
        end
        px_idx = 16;
    endtask

    task automatic chk_wins(input string tag, input int n_exp, input int base0, input int base1);
        chk({tag, "_count"}, 144'(win_q.size()), 144'(n_exp));
        for (int k = 0; k < n_exp && k < win_q.size(); k++)
            chk({tag, "_win"}, win_q[k], exp_win((k < 4) ? base0 : base1, k % 4));
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;
        int w;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0055;
        win_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_wv", 144'(win_valid), 144'(0));
        chk("rst_fd", 144'(frame_done), 144'(0));
        chk("rst_rdy", 144'(in_ready), 144'(1));
        settle();
        chk("rst_nowin", 144'(win_q.size()), 144'(0));
        chk("rst_nofd", 144'(fd_cnt), 144'(0));

        // clean frame with latency tracking
        win_q.delete();
        fd0 = fd_cnt;
        lat_en = 1;
        send_frame(0, 0);
        settle();
        lat_en = 0;
        chk_wins("clean", 4, 0, 0);
        chk("clean_fd", 144'(fd_cnt - fd0), 144'(1));

        // backpressure on the first window
        win_q.delete();
        fd0 = fd_cnt;
        win_ready = 1'b0;
        fork
            send_frame(0, 0);
            begin
                w = 0;
                @(negedge clk);
                while (win_valid !== 1'b1 && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                chk("bp_seen", 144'(win_valid), 144'(1));
                for (int i = 0; i < 5; i++) begin
                    chk("bp_hold_win", win, exp_win(0, 0));
                    chk("bp_rdy_low", 144'(in_ready), 144'(0));
                    chk("bp_px_held", 144'(px_idx), 144'(11));
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                win_ready = 1'b1;
            end
        join
        settle();
        chk_wins("bp", 4, 0, 0);
        chk("bp_fd", 144'(fd_cnt - fd0), 144'(1));

        // random input gaps
        win_q.delete();
        fd0 = fd_cnt;
        send_frame(0, 1);
        settle();
        chk_wins("gaps", 4, 0, 0);
        chk("gaps_fd", 144'(fd_cnt - fd0), 144'(1));

        // back-to-back frames
        win_q.delete();
        fd0 = fd_cnt;
        send_frame(0, 0);
        send_frame(100, 0);
        settle();
        chk_wins("b2b", 8, 0, 100);
        chk("b2b_fd", 144'(fd_cnt - fd0), 144'(2));

        // reset after pixel 9, then a full frame
        win_q.delete();
        fd0 = fd_cnt;
        for (int p = 0; p < 10; p++) send_px(16'(p), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_wv", 144'(win_valid), 144'(0));
        send_frame(0, 0);
        settle();
        chk_wins("midrst", 4, 0, 0);
        chk("midrst_fd", 144'(fd_cnt - fd0), 144'(1));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
